dpram_arb: RTL and testbench

- Arbiter and sequencer for the shared read/write port (port A) of the dual-port RAM.
- Shares that single port among NR requesters using round-robin arbitration.
- Returns registered read data and a one-cycle acknowledge to the granted requester.
- Optionally zero-fills the whole RAM after reset, since the RAM itself has no reset.
- Port X (read-only) is not touched by this block.

---
 rtl/dpram_pkg.sv | 32 +++
 rtl/dpram_arb_if.sv | 28 ++
 rtl/rr_pick.sv | 26 ++
 rtl/dpram_arb.sv | 108 ++++++++++
 tb/tb_dpram_arb.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port RAM port-A arbiter.
// The init sweep is built only when DPRAM_ARB_INIT_EN is defined.
package dpram_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned DW_DEF = 2;

    typedef enum logic {
        ST_INIT,
        ST_ARB
    } state_t;

    // One-hot round-robin winner: first set bit of req at or above ptr, modulo nr (nr <= 32).
    function automatic logic [31:0] rr_onehot(input logic [31:0] req,
                                              input int unsigned ptr,
                                              input int unsigned nr);
        logic [31:0] g;
        logic        found;
        int unsigned k;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < nr; i++) begin
            k = (ptr + i) % nr;
            if (!found && req[k[4:0]]) begin
                g[k[4:0]] = 1'b1;
                found     = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/dpram_arb_if.sv
// Requester-side bus of the port-A arbiter: flattened per-requester request
// fields plus grant, acknowledge, read data and init-busy.
interface dpram_arb_if
    import dpram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned NR = 4
);
    logic [NR-1:0]    req_i;
    logic [NR-1:0]    wre_i;
    logic [NR*AW-1:0] adr_i;
    logic [NR*DW-1:0] dat_i;
    logic [NR-1:0]    gnt_o;
    logic [NR-1:0]    ack_o;
    logic [DW-1:0]    dat_o;
    logic             busy_o;

    modport master (
        output req_i, wre_i, adr_i, dat_i,
        input  gnt_o, ack_o, dat_o, busy_o
    );

    modport slave (
        input  req_i, wre_i, adr_i, dat_i,
        output gnt_o, ack_o, dat_o, busy_o
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant, binary winner index and
// any-grant flag for a request vector searched upward from ptr.
module rr_pick
    import dpram_pkg::*;
#(
    parameter  int unsigned NR = 4,
    localparam int unsigned PW = $clog2(NR)
) (
    input  logic [NR-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NR-1:0] gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [31:0] g32;

    always_comb begin
        g32 = rr_onehot(32'(req), 32'(ptr), NR);
        gnt = g32[NR-1:0];
        any = |g32;
        idx = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (gnt[i]) idx = PW'(i);
        end
    end
endmodule

// File: rtl/dpram_arb.sv
// Round-robin arbiter/sequencer for the shared read/write port A of the DPRAM.
// Define DPRAM_ARB_INIT_EN to zero-fill the RAM with an init sweep after reset.
module dpram_arb
    import dpram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned NR = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ena_i,
    dpram_arb_if.slave    bus,
    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_wre_o,
    output logic          ram_ena_o,
    input  logic [DW-1:0] ram_dat_i
);
    localparam int unsigned PW = $clog2(NR);

`ifdef DPRAM_ARB_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
    logic [AW-1:0] cnt_q;
`else
    localparam state_t RST_STATE = ST_ARB;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win;
    logic [NR-1:0] pick_gnt;
    logic          pick_any;
    logic [NR-1:0] gnt;
    logic [NR-1:0] ack_q;
    logic [DW-1:0] dat_q;

    rr_pick #(.NR(NR)) u_pick (
        .req (bus.req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (win),
        .any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt       = '0;
        ram_adr_o = '0;
        ram_dat_o = '0;
        ram_wre_o = 1'b0;
        if (ena_i) begin
            case (state_q)
                ST_INIT: begin
`ifdef DPRAM_ARB_INIT_EN
                    ram_adr_o = cnt_q;
                    ram_wre_o = 1'b1;
                    if (cnt_q == '1) state_d = ST_ARB;
`endif
                end
                ST_ARB: begin
                    if (pick_any) begin
                        gnt       = pick_gnt;
                        ram_adr_o = bus.adr_i[win*AW +: AW];
                        ram_dat_o = bus.dat_i[win*DW +: DW];
                        ram_wre_o = bus.wre_i[win];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
            ack_q   <= '0;
            dat_q   <= '0;
        end else if (ena_i) begin
            state_q <= state_d;
            ack_q   <= gnt;
            // gnt is only non-zero in ARB, so win is valid here
            if (|gnt) begin
                ptr_q <= (win == PW'(NR - 1)) ? '0 : win + 1'b1;
                if (!bus.wre_i[win]) dat_q <= ram_dat_i;
            end
        end
    end

`ifdef DPRAM_ARB_INIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (ena_i && state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.busy_o = (state_q == ST_INIT);
`else
    assign bus.busy_o = 1'b0;
`endif

    assign bus.gnt_o = gnt;
    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_q;
    assign ram_ena_o = ena_i;
endmodule

// File: tb/tb_dpram_arb.sv
// Randomized bench for dpram_arb with a behavioural reference model and a few
// directed literal checks; covers both builds of DPRAM_ARB_INIT_EN.
module tb_dpram_arb;
    localparam int AW = 5;
    localparam int DW = 2;
    localparam int NR = 4;
    localparam int DEPTH = 1 << AW;
`ifdef DPRAM_ARB_INIT_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b1;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_wd;
    logic [DW-1:0] ram_rd;
    logic          ram_wre;
    logic          ram_ena;
    logic [DW-1:0] ram [DEPTH];

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    dpram_arb_if #(.AW(AW), .DW(DW), .NR(NR)) bus ();

    dpram_arb #(.AW(AW), .DW(DW), .NR(NR)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ena_i     (ena),
        .bus       (bus),
        .ram_adr_o (ram_adr),
        .ram_dat_o (ram_wd),
        .ram_wre_o (ram_wre),
        .ram_ena_o (ram_ena),
        .ram_dat_i (ram_rd)
    );

    always #5 clk = ~clk;

    // The RAM port A the arbiter drives: write at the edge, asynchronous read.
    initial for (int i = 0; i < DEPTH; i++) ram[i] = INIT_ON ? 2'b11 : 2'b00;
    always @(posedge clk) if (ram_ena && ram_wre) ram[ram_adr] <= ram_wd;
    assign ram_rd = ram[ram_adr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          ena;
        logic [NR-1:0] gnt;
        logic          wre;
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
        int            w;
        logic          busy;
    } exp_t;

    bit            m_init;
    int            m_cnt;
    int            m_ptr;
    logic [NR-1:0] m_ack;
    logic [DW-1:0] m_dat;
    logic [DW-1:0] m_mem [DEPTH];
    exp_t          e = '0;

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT_ON ? 2'b11 : 2'b00;

    function automatic exp_t predict();
        exp_t x;
        int   k;
        x      = '0;
        x.w    = -1;
        x.ena  = ena;
        x.busy = m_init;
        if (!ena) return x;
        if (m_init) begin
            x.wre = 1'b1;
            x.adr = m_cnt[AW-1:0];
        end else begin
            for (int i = 0; i < NR; i++) begin
                k = (m_ptr + i) % NR;
                if (x.w < 0 && bus.req_i[k]) x.w = k;
            end
            if (x.w >= 0) begin
                x.gnt = NR'(1) << x.w;
                x.wre = bus.wre_i[x.w];
                x.adr = bus.adr_i[x.w*AW +: AW];
                x.wd  = bus.dat_i[x.w*DW +: DW];
            end
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init <= INIT_ON;
            m_cnt  <= 0;
            m_ptr  <= 0;
            m_ack  <= '0;
            m_dat  <= '0;
        end else if (e.ena) begin
            if (m_init) begin
                m_mem[m_cnt] <= '0;
                m_ack        <= '0;
                m_cnt        <= (m_cnt == DEPTH - 1) ? 0 : m_cnt + 1;
                if (m_cnt == DEPTH - 1) m_init <= 1'b0;
            end else begin
                m_ack <= e.gnt;
                if (e.w >= 0) begin
                    m_ptr <= (e.w + 1) % NR;
                    if (e.wre) m_mem[e.adr] <= e.wd;
                    else       m_dat <= m_mem[e.adr];
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        x = predict();
        e <= x;
        if (chk_on) begin
            chk("gnt", bus.gnt_o, x.gnt);
            chk("busy", bus.busy_o, x.busy);
            chk("ack", bus.ack_o, m_ack);
            chk("dat_o", bus.dat_o, m_dat);
            chk("ram_ena", ram_ena, ena);
            chk("ram_wre", ram_wre, x.wre);
            if (ena) begin
                chk("ram_adr", ram_adr, x.adr);
                chk("ram_dat", ram_wd, x.wd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit r, input bit w, input int a, input int d);
        bus.req_i[k]             = r;
        bus.wre_i[k]             = w;
        bus.adr_i[k*AW +: AW]    = a[AW-1:0];
        bus.dat_i[k*DW +: DW]    = d[DW-1:0];
    endtask

    task automatic sweep_chk(input int c);
        chk("sweep_busy", bus.busy_o, 1);
        chk("sweep_adr", ram_adr, c);
        chk("sweep_wre", ram_wre, 1);
        chk("sweep_dat", ram_wd, 0);
        chk("sweep_gnt", bus.gnt_o, 0);
    endtask

    initial begin
        logic [NR-1:0] rr_seq [5];
        logic [NR-1:0] prev_g;
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req_i = '0;
        bus.wre_i = '0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_ack", bus.ack_o, 0);
        chk("rst_dat", bus.dat_o, 0);
        chk("rst_busy", bus.busy_o, INIT_ON);
        chk("rst_gnt", bus.gnt_o, 0);

        step();
        rst_n = 1'b1;
        for (int k = 0; k < NR; k++) set_req(k, 1, 0, 10 + k, 0);
        #3;
`ifdef DPRAM_ARB_INIT_EN
        for (int c = 0; c < 17; c++) begin
            sweep_chk(c);
            step();
            #3;
        end
        chk("mid_adr", ram_adr, 17);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #3;
        for (int c = 0; c < DEPTH; c++) begin
            sweep_chk(c);
            step();
            #3;
        end
        chk("sweep_done", bus.busy_o, 0);
`endif
        for (int j = 0; j < 5; j++) begin
            chk("rr_gnt", bus.gnt_o, rr_seq[j]);
            if (j > 0) chk("rr_ack", bus.ack_o, rr_seq[j-1]);
            step();
            if (j < 4) #3;
        end

        for (int k = 0; k < NR; k++) set_req(k, 0, 0, 0, 0);
        set_req(0, 1, 1, 5, 2);
        #3;
        chk("rr_ack_last", bus.ack_o, 4'b0001);
        chk("wr_gnt", bus.gnt_o, 4'b0001);
        chk("wr_wre", ram_wre, 1);
        chk("wr_adr", ram_adr, 5);
        chk("wr_dat", ram_wd, 2);
        step();
        set_req(0, 0, 0, 0, 0);
        set_req(2, 1, 0, 5, 0);
        #3;
        chk("rd_gnt", bus.gnt_o, 4'b0100);
        chk("wr_ack", bus.ack_o, 4'b0001);
        step();
        set_req(2, 0, 0, 0, 0);
        #3;
        chk("rd_ack", bus.ack_o, 4'b0100);
        chk("raw_dat", bus.dat_o, 2'b10);

        step();
        set_req(0, 1, 0, 7, 0);
        set_req(2, 1, 0, 9, 0);
        #3;
        chk("pre_stall_gnt", bus.gnt_o, 4'b0001);
        for (int s = 0; s < 3; s++) begin
            step();
            ena = 1'b0;
            #3;
            chk("stall_gnt", bus.gnt_o, 0);
            chk("stall_wre", ram_wre, 0);
            chk("stall_ack", bus.ack_o, 4'b0001);
            chk("stall_dat", bus.dat_o, 0);
        end
        step();
        ena = 1'b1;
        #3;
        chk("resume_gnt", bus.gnt_o, 4'b0100);
        chk("resume_ack", bus.ack_o, 4'b0001);

        step();
        for (int k = 0; k < NR; k++) set_req(k, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(1, 1, 0, 3, 0);
        #3;
`ifdef DPRAM_ARB_INIT_EN
        chk("post_rst_busy", bus.busy_o, 1);
        chk("post_rst_gnt", bus.gnt_o, 0);
`else
        chk("post_rst_busy", bus.busy_o, 0);
        chk("post_rst_gnt", bus.gnt_o, 4'b0010);
`endif

        prev_g = bus.gnt_o;
        for (int it = 0; it < 3000; it++) begin
            step();
            if (it == 1500) rst_n = 1'b0;
            if (it == 1501) rst_n = 1'b1;
            ena = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < NR; k++) begin
                if (!(bus.req_i[k] && !prev_g[k])) begin
                    set_req(k, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
                end
            end
            #3;
            prev_g = bus.gnt_o;
        end
        step();
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
